// File: rtl/binary_divider_if.sv
// Handshake and result bus for the restoring binary divider.
interface binary_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  // Requester side: issues operands, observes status and results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/binary_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, fixed latency,
// divide-by-zero reported as all-ones quotient with the dividend as remainder.
module binary_divider #(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  binary_divider_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted_r;
  logic [WIDTH:0]   trial;

  // One restoring step: shift the next dividend bit in, try subtracting the divisor.
  assign shifted_r = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial     = shifted_r - {1'b0, dvs};

  // Controller, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dvd           <= '0;
      dvs           <= '0;
      r             <= '0;
      q             <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.dbz       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd      <= bus.dividend;
            dvs      <= bus.divisor;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          r   <= '0;
          q   <= dvd;
          cnt <= CNT_W'(WIDTH);
          if (dvs == '0) begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          // A set top bit of trial means the subtraction went negative: restore.
          r   <= trial[WIDTH] ? shifted_r : trial;
          q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          if (dvs == '0) begin
            bus.quotient  <= '1;
            bus.remainder <= dvd;
            bus.dbz       <= 1'b1;
          end else begin
            bus.quotient  <= q;
            bus.remainder <= r[WIDTH-1:0];
            bus.dbz       <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_divider.sv
// Directed and soak checks for binary_divider.
module tb_binary_divider;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [15:0] prev_q;
  logic [15:0] prev_r;

  binary_divider_if #(.WIDTH(16)) bus ();

  binary_divider #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One start pulse, then verify latency, busy length, results and output hold.
  task automatic do_div(input vec_t v);
    int lat;
    int busy_cycles;
    logic hold_bad;
    lat = 0;
    busy_cycles = 0;
    hold_bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = v.a;
    bus.divisor = v.b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = ~v.a;
    bus.divisor = ~v.b;
    if (bus.busy) busy_cycles++;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.busy) busy_cycles++;
      if (bus.quotient !== prev_q || bus.remainder !== prev_r) hold_bad = 1'b1;
    end
    check("latency", 32'(lat), (v.b == 16'h0) ? 32'd2 : 32'd18);
    check("busy_len", 32'(busy_cycles), (v.b == 16'h0) ? 32'd1 : 32'd17);
    check("hold_during_busy", 32'(hold_bad), 32'd0);
    check("quotient", 32'(bus.quotient), 32'(v.q));
    check("remainder", 32'(bus.remainder), 32'(v.r));
    check("dbz", 32'(bus.dbz), 32'(v.z));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("quotient_held", 32'(bus.quotient), 32'(v.q));
    prev_q = v.q;
    prev_r = v.r;
  endtask

  initial begin
    int dones;
    int cycles;
    logic [15:0] got_q;
    logic [15:0] got_r;
    logic [15:0] a;
    logic [15:0] b;
    errors = 0;
    checks = 0;
    prev_q = '0;
    prev_r = '0;

    vecs[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
    vecs[1]  = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000,  1'b0};
    vecs[3]  = '{16'h8000,  16'h8001,  16'h0000,  16'h8000,  1'b0};
    vecs[4]  = '{16'd5,     16'd9,     16'd0,     16'd5,     1'b0};
    vecs[5]  = '{16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1};
    vecs[6]  = '{16'd10,    16'd3,     16'd3,     16'd1,     1'b0};
    vecs[7]  = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
    vecs[8]  = '{16'd12345, 16'd123,   16'd100,   16'd45,    1'b0};
    vecs[9]  = '{16'hFFFE,  16'h8000,  16'h0001,  16'h7FFE,  1'b0};
    vecs[10] = '{16'd65535, 16'd256,   16'd255,   16'd255,   1'b0};
    vecs[11] = '{16'd1000,  16'd10,    16'd100,   16'd0,     1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) do_div(vecs[i]);

    // Second start and operand changes mid-run must neither queue nor disturb.
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor = 16'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd7;
    bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 16'h5555;
    bus.divisor = 16'h0000;
    dones = 0;
    got_q = '0;
    got_r = '0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        got_q = bus.quotient;
        got_r = bus.remainder;
      end
    end
    check("ignore_start_dones", 32'(dones), 32'd1);
    check("ignore_start_q", 32'(got_q), 32'd100);
    check("ignore_start_r", 32'(got_r), 32'd0);
    check("ignore_start_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of CALC aborts with no done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd500;
    bus.divisor = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_quotient", 32'(bus.quotient), 32'd0);
    check("arst_remainder", 32'(bus.remainder), 32'd0);
    check("arst_dbz", 32'(bus.dbz), 32'd0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("start_in_rst", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    prev_q = '0;
    prev_r = '0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    do_div('{16'd500, 16'd3, 16'd166, 16'd2, 1'b0});

    // Back-to-back soak with start held high; operands change in the IDLE cycle.
    @(negedge clk);
    a = 16'($urandom);
    b = 16'($urandom_range(65535, 1));
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        cycles++;
        if (bus.done) break;
      end
      check("soak_period", 32'(cycles), 32'd19);
      check("soak_q", 32'(bus.quotient), 32'(a / b));
      check("soak_r", 32'(bus.remainder), 32'(a % b));
      if (bus.dbz !== 1'b0) check("soak_dbz", 32'(bus.dbz), 32'd0);
      a = 16'($urandom);
      b = (n % 4 == 0) ? 16'($urandom_range(15, 1)) : 16'($urandom_range(65535, 1));
      bus.dividend = a;
      bus.divisor = b;
      if (n == 299) bus.start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("soak_stops", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
